// File: rtl/mem_stage_pkg.sv
// Shared constants and pipeline-register layouts for the memory stage.
// Bubble encoding is all-zero: no load, no store, no register write.
package mem_stage_pkg;

    localparam int XLEN           = 32;
    localparam int RIDX_W         = 5;
    localparam int DMEM_DEPTH_DEF = 256;

    typedef struct packed {
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   sdata;
        logic [RIDX_W-1:0] dest;
        logic              mem_r;
        logic              mem_w;
        logic              wb_en;
    } exmem_t;

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [RIDX_W-1:0] dest;
        logic              wb_en;
        logic              misalign;
    } memwb_t;

    localparam exmem_t EXMEM_BUBBLE = '0;
    localparam memwb_t MEMWB_RESET  = '0;

endpackage

// File: rtl/mem_stage_dmem.sv
// Word-addressed data memory: one synchronous write port, asynchronous read.
// Contents are never reset; the caller qualifies the write enable.
module mem_stage_dmem
    import mem_stage_pkg::*;
#(
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter int AW         = $clog2(DMEM_DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_idx,
    input  logic [XLEN-1:0] i_wr_dat,
    output logic [XLEN-1:0] o_rd_dat
);

    logic [XLEN-1:0] r_mem [DMEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_idx];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM and MEM/WB registers around a local data memory; 2-edge latency, hold freezes both.
// MEM_MISALIGN_CHECK_EN enables misaligned-access detection (store suppressed, load zeroed).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter int AW         = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hold,
    input  logic              i_flush,
    input  logic [XLEN-1:0]   i_alu_out,
    input  logic [XLEN-1:0]   i_st_data_out,
    input  logic [RIDX_W-1:0] i_reg_dest,
    input  logic              i_mem_r,
    input  logic              i_mem_w,
    input  logic              i_wb_en,
    output logic [XLEN-1:0]   o_fwd_mem_data,
    output logic [RIDX_W-1:0] o_fwd_mem_dest,
    output logic              o_fwd_mem_wb_en,
    output logic              o_fwd_mem_is_load,
    output logic [XLEN-1:0]   o_wb_data,
    output logic [RIDX_W-1:0] o_wb_dest,
    output logic              o_wb_en_out,
    output logic              o_misalign
);

    exmem_t          r_ex;
    exmem_t          w_ex_nxt;
    memwb_t          r_wb;
    memwb_t          w_wb_nxt;
    logic [AW-1:0]   w_idx;
    logic [XLEN-1:0] w_rd_dat;
    logic            w_mis;
    logic            w_we;

    // Upper address bits are dropped here, so addresses wrap over the array.
    assign w_idx = r_ex.alu[AW+1:2];

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_mis = (r_ex.mem_r | r_ex.mem_w) & (r_ex.alu[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    // A store writes only on the edge that advances it out of MEM.
    assign w_we = r_ex.mem_w & ~w_mis & ~i_hold & i_rst;

    mem_stage_dmem #(
        .DMEM_DEPTH (DMEM_DEPTH),
        .AW         (AW)
    ) u_dmem (
        .i_clk    (i_clk),
        .i_we     (w_we),
        .i_idx    (w_idx),
        .i_wr_dat (r_ex.sdata),
        .o_rd_dat (w_rd_dat)
    );

    always_comb begin
        w_ex_nxt       = EXMEM_BUBBLE;
        w_ex_nxt.alu   = i_alu_out;
        w_ex_nxt.sdata = i_st_data_out;
        w_ex_nxt.dest  = i_reg_dest;
        w_ex_nxt.mem_r = i_mem_r;
        w_ex_nxt.mem_w = i_mem_w;
        w_ex_nxt.wb_en = i_wb_en;

        w_wb_nxt          = MEMWB_RESET;
        w_wb_nxt.data     = r_ex.mem_r ? w_rd_dat : r_ex.alu;
        w_wb_nxt.dest     = r_ex.dest;
        w_wb_nxt.wb_en    = r_ex.wb_en;
        w_wb_nxt.misalign = w_mis;
        if (w_mis && r_ex.mem_r) begin
            w_wb_nxt.data  = '0;
            w_wb_nxt.wb_en = 1'b0;
        end
    end

    // Flush only touches EX/MEM; MEM/WB still advances unless held.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ex <= EXMEM_BUBBLE;
            r_wb <= MEMWB_RESET;
        end else begin
            if (i_flush) begin
                r_ex <= EXMEM_BUBBLE;
            end else if (!i_hold) begin
                r_ex <= w_ex_nxt;
            end
            if (!i_hold) begin
                r_wb <= w_wb_nxt;
            end
        end
    end

    assign o_fwd_mem_data    = r_ex.alu;
    assign o_fwd_mem_dest    = r_ex.dest;
    assign o_fwd_mem_wb_en   = r_ex.wb_en;
    assign o_fwd_mem_is_load = r_ex.mem_r;
    assign o_wb_data         = r_wb.data;
    assign o_wb_dest         = r_wb.dest;
    assign o_wb_en_out       = r_wb.wb_en;
    assign o_misalign        = r_wb.misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expectations queued at issue, compared as instructions retire.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk = 1'b0;
    logic        rst, hold, flush, mem_r, mem_w, wb_en;
    logic [31:0] alu_out, st_data;
    logic [4:0]  reg_dest;
    logic [31:0] fwd_mem_data, wb_data;
    logic [4:0]  fwd_mem_dest, wb_dest;
    logic        fwd_mem_wb_en, fwd_mem_is_load, wb_en_out, misalign;

    always #5 clk = ~clk;

    mem_stage #(.DMEM_DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_hold            (hold),
        .i_flush           (flush),
        .i_alu_out         (alu_out),
        .i_st_data_out     (st_data),
        .i_reg_dest        (reg_dest),
        .i_mem_r           (mem_r),
        .i_mem_w           (mem_w),
        .i_wb_en           (wb_en),
        .o_fwd_mem_data    (fwd_mem_data),
        .o_fwd_mem_dest    (fwd_mem_dest),
        .o_fwd_mem_wb_en   (fwd_mem_wb_en),
        .o_fwd_mem_is_load (fwd_mem_is_load),
        .o_wb_data         (wb_data),
        .o_wb_dest         (wb_dest),
        .o_wb_en_out       (wb_en_out),
        .o_misalign        (misalign)
    );

    typedef struct {
        logic [31:0] fdata;
        logic [4:0]  fdest;
        logic        fwen;
        logic        fld;
        logic [31:0] wdata;
        logic [4:0]  wdest;
        logic        wen;
        logic        wmis;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        last_wb;
    exp_t        bubble;
    logic [31:0] model_mem [DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic cmp_outputs(input string t);
        check({t, ":fwd_data"},  fwd_mem_data,           exp_q[0].fdata);
        check({t, ":fwd_dest"},  32'(fwd_mem_dest),      32'(exp_q[0].fdest));
        check({t, ":fwd_wben"},  32'(fwd_mem_wb_en),     32'(exp_q[0].fwen));
        check({t, ":fwd_load"},  32'(fwd_mem_is_load),   32'(exp_q[0].fld));
        check({t, ":wb_data"},   wb_data,                last_wb.wdata);
        check({t, ":wb_dest"},   32'(wb_dest),           32'(last_wb.wdest));
        check({t, ":wb_en"},     32'(wb_en_out),         32'(last_wb.wen));
        check({t, ":misalign"},  32'(misalign),          32'(last_wb.wmis));
    endtask

    // One clock with the given inputs; expectations derived from the model memory in program order.
    task automatic step(input string t, input logic h, input logic f, input logic r, input logic w,
                        input logic we, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d);
        exp_t            e;
        logic            mis;
        logic [AW-1:0]   idx;
        hold = h; flush = f; mem_r = r; mem_w = w; wb_en = we;
        alu_out = a; st_data = sd; reg_dest = d;
        @(posedge clk);
        #1;
        if (!h) begin
`ifdef MEM_MISALIGN_CHECK_EN
            mis = (r | w) && (a[1:0] != 2'b00);
`else
            mis = 1'b0;
`endif
            idx = a[AW+1:2];
            if (f) begin
                e = bubble;
            end else begin
                e.fdata = a; e.fdest = d; e.fwen = we; e.fld = r;
                e.wdest = d; e.wmis = mis;
                e.wdata = r ? (mis ? 32'h0 : model_mem[idx]) : a;
                e.wen   = (r && mis) ? 1'b0 : we;
                if (w && !mis) model_mem[idx] = sd;
            end
            exp_q.push_back(e);
            last_wb = exp_q.pop_front();
        end
        cmp_outputs(t);
    endtask

    task automatic nop(input string t);
        step(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic do_reset(input int edges);
        rst = 1'b0;
        for (int i = 0; i < edges; i++) begin
            hold = 1'($urandom); flush = 1'($urandom); mem_r = 1'($urandom);
            mem_w = 1'($urandom); wb_en = 1'($urandom);
            alu_out = $urandom; st_data = $urandom; reg_dest = 5'($urandom);
            @(posedge clk);
        end
        #1;
        exp_q.delete();
        exp_q.push_back(bubble);
        last_wb = bubble;
        cmp_outputs("reset");
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] saved;
        bubble = '{32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0};
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        do_reset(2);

        // Store then load, then ALU pass-through, then drain.
        step("st10",   0, 0, 0, 1, 0, 32'h10,   32'hDEADBEEF, 5'd0);
        step("ld10",   0, 0, 1, 0, 1, 32'h10,   32'h0,        5'd5);
        step("alu",    0, 0, 0, 0, 1, 32'h1234, 32'h0,        5'd3);
        nop("drain0");
        nop("drain1");

        // Held store: memory keeps the prior value until the store is released.
        step("st20a",  0, 0, 0, 1, 0, 32'h20, 32'h11111111, 5'd0);
        step("st20b",  0, 0, 0, 1, 0, 32'h20, 32'hA5A5A5A5, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1, 0, 1, 0, 1, $urandom, $urandom, 5'($urandom));
            check("hold:mem8_prior", dut.u_dmem.r_mem[8], 32'h11111111);
        end
        step("ld20",   0, 0, 1, 0, 1, 32'h20, 32'h0, 5'd7);
        check("hold:mem8_written", dut.u_dmem.r_mem[8], 32'hA5A5A5A5);
        nop("drain2");
        nop("drain3");

        // Flush: flushed store is dropped, store already in MEM survives.
        step("st30",   0, 0, 0, 1, 0, 32'h30, 32'h33333333, 5'd0);
        step("st40",   0, 0, 0, 1, 0, 32'h40, 32'h44444444, 5'd0);
        step("flushA", 0, 1, 0, 1, 1, 32'h30, 32'h00000BAD, 5'd9);
        step("flushB", 0, 1, 0, 0, 1, 32'h55, 32'h0,        5'd9);
        step("ld30",   0, 0, 1, 0, 1, 32'h30, 32'h0, 5'd10);
        step("ld40",   0, 0, 1, 0, 1, 32'h40, 32'h0, 5'd11);

        // Address wrap modulo 4*DEPTH.
        step("stwrap", 0, 0, 0, 1, 0, 32'(4 * DEPTH + 8), 32'hCAFEF00D, 5'd0);
        step("ld8",    0, 0, 1, 0, 1, 32'h8, 32'h0, 5'd12);
        nop("drain4");

        // Misaligned accesses; without the check they act as aligned word accesses.
        step("stmis",  0, 0, 0, 1, 0, 32'h21, 32'h1, 5'd0);
        step("ldmis",  0, 0, 1, 0, 1, 32'h22, 32'h0, 5'd6);
        step("ld20c",  0, 0, 1, 0, 1, 32'h20, 32'h0, 5'd4);
        nop("drain5");
        nop("drain6");

        // Reset while a store sits in MEM: the store is dropped.
        saved = model_mem[16];
        step("st40x",  0, 0, 0, 1, 0, 32'h40, 32'h99999999, 5'd0);
        model_mem[16] = saved;
        do_reset(1);
        step("ld40b",  0, 0, 1, 0, 1, 32'h40, 32'h0, 5'd13);
        nop("drain7");

        // Randomised mix over a small initialised window, with holds and flushes.
        for (int i = 0; i < 8; i++) step("init", 0, 0, 0, 1, 0, 32'(i * 4), $urandom, 5'd0);
        for (int i = 0; i < 60; i++) begin
            logic        h, f;
            int          op;
            logic [31:0] a;
            h  = ($urandom_range(0, 3) == 0);
            f  = !h && ($urandom_range(0, 7) == 0);
            op = $urandom_range(0, 2);
            a  = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 10);
            step("rand", h, f, op == 1, op == 2, op != 2, a, $urandom, 5'($urandom));
        end
        nop("drain8");
        nop("drain9");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline, directly downstream of the execute stage. Latches the execute-stage ALU result and store data into the EX/MEM register and performs word loads and stores against a local data memory. Produces the MEM/WB register for write-back. Also drives the MEM- and WB-position forwarding values and destination tags that the forwarding and hazard logic route back to execute.

## Interface
Parameters:
- DMEM_DEPTH, 256: data memory size in 32-bit words; power of two.
- AW, 8: word-index width, log2(DMEM_DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- hold  in  1  freeze both pipeline registers; suppresses memory write.
- flush  in  1  load a bubble into EX/MEM.
- alu_out  in  32  execute-stage result; used as byte address for loads and stores.
- st_data_out  in  32  execute-stage store data, already forwarded.
- reg_dest  in  5  destination register.
- mem_r, mem_w, wb_en  in  1 each  load, store and register-write controls.
- fwd_mem_data  out  32  EX/MEM ALU result; drives the execute-stage MEM forward input.
- fwd_mem_dest  out  5  EX/MEM destination.
- fwd_mem_wb_en  out  1  EX/MEM write-enable.
- fwd_mem_is_load  out  1  EX/MEM mem_r; feeds load-use stall detection.
- wb_data  out  32  MEM/WB result; also drives the execute-stage WB forward input.
- wb_dest  out  5  MEM/WB destination.
- wb_en_out  out  1  MEM/WB write-enable.
- misalign  out  1  MEM/WB misaligned-access flag.

## Operation
- EX/MEM register fields: addr/alu (32), sdata (32), dest (5), mem_r, mem_w, wb_en.
- Update priority on each edge: reset > flush > hold > normal load.
  - Reset: every register field is 0.
  - Flush: EX/MEM control bits and dest are 0. Data fields are don't-care; implement them as 0.
  - Hold: both registers keep their value.
  - Normal: EX/MEM captures the inputs, and MEM/WB captures the MEM-stage result.
- Memory index is addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DMEM_DEPTH.
- Loads:
  - Read is combinational from the array during the MEM cycle.
  - MEM/WB wb_data = mem_r ? dmem[idx] : alu.
- Stores:
  - Write dmem[idx] = sdata on the edge that ends the MEM cycle.
  - Only when mem_w=1 and hold=0 and rst=1.
  - Exactly one write per store instruction, even when held for several cycles.
- Store followed immediately by a load to the same word: the load reads the new data.
- Memory contents are not cleared by reset.
- A flush in the same cycle as a store in MEM does not cancel that store. Flush acts only on EX/MEM capture.
- Reset outputs: all fwd_*, wb_*, and misalign are 0.

## Timing
- Instruction in execute during cycle N:
  - visible on fwd_mem_* in cycle N+1;
  - visible on wb_* in cycle N+2.
- Latency is two edges; throughput is one instruction per cycle when hold=0.
- There are no combinational input-to-output paths. Every output is a register or is decoded from one.
- Reset asserted mid-operation: the next edge clears both registers, and any store in MEM that cycle is dropped.

## Configuration
- MEM_MISALIGN_CHECK_EN: misaligned-access checking.
- Defined: an access with mem_r or mem_w set and addr[1:0] != 0 is treated as misaligned.
  - A misaligned store is suppressed.
  - A misaligned load captures wb_data=0 and wb_en_out=0.
  - In both cases misalign=1 in MEM/WB for one instruction.
- Undefined: addr[1:0] is ignored and misalign is tied 0. The port always exists.

## Structure
- Shared constants header holds:
  - the word width (32);
  - the register-index width (5);
  - the bubble encoding (all controls 0);
  - the DMEM_DEPTH default.
- One sub-module, dmem: a single-write-port word array with asynchronous read, parameterised on DMEM_DEPTH. mem_stage owns both pipeline registers and the write-enable qualification.

## Test plan
- Reset: hold rst=0 for two edges with arbitrary inputs -> every output is 0.
- Store then load:
  - Stimulus: store 0xDEADBEEF to address 0x10, then in the next cycle load 0x10 with dest=5, wb_en=1.
  - Required: two cycles after the load, wb_data=0xDEADBEEF, wb_dest=5, wb_en_out=1.
- ALU pass-through:
  - Stimulus: alu_out=0x1234, mem_r=0, dest=3.
  - Required: fwd_mem_data=0x1234 at N+1; wb_data=0x1234 at N+2.
- Hold:
  - Stimulus: store 0xA5A5A5A5 to 0x20, then hold=1 for 3 cycles.
  - Required: outputs frozen; after release, a load of 0x20 returns 0xA5A5A5A5.
  - Required: while the store is held, the location is written with a single write (verified via an extra prior value check).
- Flush and wrap:
  - Stimulus: flush with wb_en=1 at input.
  - Required: fwd_mem_wb_en=0.
  - Stimulus: store to address 4*DMEM_DEPTH+8, then load 8.
  - Required: the load returns the stored value.
- Misalign (macro defined):
  - Stimulus: store 0x1 to address 0x21.
  - Required: misalign=1, and memory word 8 is unchanged.
  - Stimulus: load from 0x22.
  - Required: wb_en_out=0 and misalign=1.
